uop_sequencer: RTL and testbench
================================

UOP_SEQUENCER -- requirements
Module: uop_sequencer

Interface
REQ-001 SHALL have parameter UOP_W, default 3, micro-op counter width.
REQ-002 SHALL have parameter CNT_W, default 16, retired-instruction counter width.
REQ-003 SHALL have port CLK, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port RESET, input, 1, synchronous, active-high reset.
REQ-005 SHALL have port RESET_UOP, input, 1, end-of-instruction strobe from the controller ROM.
REQ-006 SHALL have port READ_FLAGS, input, 1, flag-capture strobe from the controller ROM.
REQ-007 SHALL have ports ZERO_IN and COUT_IN, input, 1 each, raw ALU flags.
REQ-008 SHALL have ports RUN, HALT and STEP, input, 1 each, run-control requests, level-sampled.
REQ-009 SHALL have port UOP, output, UOP_W, current micro-op to the controller ROM.
REQ-010 SHALL have ports ZERO_FLAG and COUT_FLAG, output, 1 each, registered flags to the controller ROM.
REQ-011 SHALL have ports BUSY and HALTED, output, 1 each, run-state indicators.
REQ-012 SHALL have port FAULT, output, 1, sticky runaway-instruction indicator.
REQ-013 SHALL have port INSTR_CNT, output, CNT_W, retired-instruction count.

Function
REQ-014 SHALL implement states IDLE, RUN, STEP and HALT_ST; UOP = 7 (ROM idle word) in IDLE and HALT_ST.
REQ-015 SHALL go IDLE -> RUN one cycle after reset release, and UOP SHALL be 0 on that first RUN cycle.
REQ-016 SHALL set next UOP to 0 in RUN or STEP when RESET_UOP = 1, else to UOP+1.
REQ-017 SHALL, in RUN or STEP with UOP = 6 and RESET_UOP = 0, set next UOP to 0 and set FAULT; FAULT clears only on RESET.
REQ-018 SHALL latch a HALT request (HALT = 1 in RUN) into a pending bit; on the next cycle with RESET_UOP = 1, SHALL enter HALT_ST and clear the pending bit; a halt never interrupts an instruction mid-sequence.
REQ-019 SHALL, with HALT = 1 and RESET_UOP = 1 in the same RUN cycle, enter HALT_ST directly.
REQ-020 SHALL, in HALT_ST with STEP = 1, enter STEP with UOP = 0 next cycle and return to HALT_ST at the RESET_UOP of that instruction.
REQ-021 SHALL, in HALT_ST with RUN = 1 and HALT = 0, enter RUN with UOP = 0; in HALT_ST, RUN takes priority over STEP.
REQ-022 SHALL, in HALT_ST with HALT = 1, stay in HALT_ST regardless of RUN, except that STEP = 1 still executes one instruction.
REQ-023 SHALL ignore STEP outside HALT_ST and ignore RUN in RUN and STEP.
REQ-024 SHALL load ZERO_FLAG/COUT_FLAG from ZERO_IN/COUT_IN on each edge with READ_FLAGS = 1 in RUN or STEP (last capture wins), else hold.
REQ-025 SHALL assert BUSY in RUN and STEP, and HALTED in HALT_ST only.
REQ-026 SHALL increment INSTR_CNT by 1 on each RESET_UOP = 1 cycle in RUN or STEP, wrapping modulo 2^CNT_W; a FAULT-forced restart SHALL NOT count.

Reset
REQ-027 SHALL, on RESET = 1 at a clock edge, enter IDLE with UOP = 7, flags 0, FAULT 0, INSTR_CNT 0, halt pending 0, BUSY 0 and HALTED 0.
REQ-028 SHALL let RESET mid-instruction abort at once, with no count increment and no flag capture on that edge.

Configuration
REQ-029 SHALL, with macro UOP_SEQUENCER_INSTR_CNT_EN defined, include the retired-instruction counter per REQ-026.
REQ-030 SHALL, without UOP_SEQUENCER_INSTR_CNT_EN, tie INSTR_CNT to 0, instantiate no counter flops, and leave all other behaviour unchanged.

Structure
REQ-031 SHALL place in shared package uop_sequencer_pkg: the state enum, UOP_FETCH = 0, UOP_IDLE = 7 and UOP_LAST = 6.
REQ-032 SHALL keep the counter as one sub-module, instr_counter (sync clear, enable, wrap), instantiated only under the macro; all else stays in one module.

Verification
REQ-033 SHALL cover: reset, then RESET_UOP at UOP 3 -> UOP sequence 7,0,1,2,3,0; INSTR_CNT = 1.
REQ-034 SHALL cover: HALT pulse at UOP 1, RESET_UOP at UOP 4 -> UOP 2,3,4, then 7; HALTED = 1; BUSY = 0.
REQ-035 SHALL cover: in HALT_ST, STEP pulse, RESET_UOP at UOP 3 -> UOP 0..3, then 7; INSTR_CNT +1; HALTED re-asserts.
REQ-036 SHALL cover: READ_FLAGS at UOP 4 (ZERO_IN = 1) and UOP 5 (ZERO_IN = 0, COUT_IN = 1) -> ZERO_FLAG = 0, COUT_FLAG = 1.
REQ-037 SHALL cover: RESET_UOP never asserted -> UOP 0..6 then 0; FAULT = 1 and stays 1; INSTR_CNT unchanged.
REQ-038 SHALL cover: INSTR_CNT preset near 0xFFFF, two retirements -> 0xFFFF then 0x0000; without the macro, INSTR_CNT = 0 throughout.

Source files
------------

// File: rtl/uop_sequencer_pkg.sv
// Shared state encoding and micro-op constants for the micro-op sequencer.
// The sequencer and its bench import these so the ROM word values stay in one place.
package uop_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_HALT = 2'd3
  } state_e;

  localparam int UOP_FETCH = 0;
  localparam int UOP_LAST  = 6;
  localparam int UOP_IDLE  = 7;

  function automatic logic is_busy(input state_e s);
    return (s == ST_RUN) || (s == ST_STEP);
  endfunction

endpackage

// File: rtl/uop_sequencer_instr_counter.sv
// Wrapping retired-instruction counter with synchronous clear and count enable.
module instr_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (clr)     cnt <= '0;
    else if (en) cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/uop_sequencer.sv
// Micro-op sequencer: steps the controller ROM micro-op, captures ALU flags, handles run/halt/step.
// Define UOP_SEQUENCER_INSTR_CNT_EN to build the retired-instruction counter; otherwise INSTR_CNT is 0.
module uop_sequencer
  import uop_sequencer_pkg::*;
#(
  parameter int UOP_W = 3,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             RESET_UOP,
  input  logic             READ_FLAGS,
  input  logic             ZERO_IN,
  input  logic             COUT_IN,
  input  logic             RUN,
  input  logic             HALT,
  input  logic             STEP,
  output logic [UOP_W-1:0] UOP,
  output logic             ZERO_FLAG,
  output logic             COUT_FLAG,
  output logic             BUSY,
  output logic             HALTED,
  output logic             FAULT,
  output logic [CNT_W-1:0] INSTR_CNT
);

  localparam logic [UOP_W-1:0] FETCH_W = UOP_W'(UOP_FETCH);
  localparam logic [UOP_W-1:0] LAST_W  = UOP_W'(UOP_LAST);
  localparam logic [UOP_W-1:0] IDLE_W  = UOP_W'(UOP_IDLE);

  state_e           state, state_nxt;
  logic [UOP_W-1:0] uop_nxt;
  logic             halt_pend, halt_pend_nxt;
  logic             fault_nxt;
  logic             busy;

  assign busy   = is_busy(state);
  assign BUSY   = busy;
  assign HALTED = (state == ST_HALT);

  // NOTE: every variable gets a default before the case so no path can infer a latch.
  always_comb begin
    state_nxt     = state;
    uop_nxt       = UOP;
    halt_pend_nxt = halt_pend;
    fault_nxt     = FAULT;
    unique case (state)
      ST_IDLE: begin
        state_nxt = ST_RUN;
        uop_nxt   = FETCH_W;
      end
      ST_RUN, ST_STEP: begin
        if (state == ST_RUN && HALT) halt_pend_nxt = 1'b1;
        if (RESET_UOP) begin
          uop_nxt = FETCH_W;
          // Halts only take effect on an instruction boundary.
          if (state == ST_STEP || HALT || halt_pend) begin
            state_nxt     = ST_HALT;
            uop_nxt       = IDLE_W;
            halt_pend_nxt = 1'b0;
          end
        end else if (UOP == LAST_W) begin
          uop_nxt   = FETCH_W;
          fault_nxt = 1'b1;
        end else begin
          uop_nxt = UOP + UOP_W'(1);
        end
      end
      ST_HALT: begin
        if (RUN && !HALT) begin
          state_nxt = ST_RUN;
          uop_nxt   = FETCH_W;
        end else if (STEP) begin
          state_nxt = ST_STEP;
          uop_nxt   = FETCH_W;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= ST_IDLE;
      UOP       <= IDLE_W;
      halt_pend <= 1'b0;
      FAULT     <= 1'b0;
      ZERO_FLAG <= 1'b0;
      COUT_FLAG <= 1'b0;
    end else begin
      state     <= state_nxt;
      UOP       <= uop_nxt;
      halt_pend <= halt_pend_nxt;
      FAULT     <= fault_nxt;
      if (busy && READ_FLAGS) begin
        ZERO_FLAG <= ZERO_IN;
        COUT_FLAG <= COUT_IN;
      end
    end
  end

`ifdef UOP_SEQUENCER_INSTR_CNT_EN
  // A fault-forced restart is not a retirement, so only RESET_UOP counts.
  logic retire;
  assign retire = busy && RESET_UOP;

  instr_counter #(.W(CNT_W)) u_instr_counter (
    .clk (CLK),
    .clr (RESET),
    .en  (retire),
    .cnt (INSTR_CNT)
  );
`else
  assign INSTR_CNT = '0;
`endif

endmodule

// File: tb/tb_uop_sequencer.sv
// Self-checking bench for uop_sequencer: table of per-cycle vectors with a scoreboard of
// expected post-edge outputs, plus a counter-wrap sequence.
module tb_uop_sequencer;

  logic        CLK = 1'b0;
  logic        RESET, RESET_UOP, READ_FLAGS, ZERO_IN, COUT_IN, RUN, HALT, STEP;
  logic [2:0]  UOP;
  logic        ZERO_FLAG, COUT_FLAG, BUSY, HALTED, FAULT;
  logic [15:0] INSTR_CNT;

  uop_sequencer #(.UOP_W(3), .CNT_W(16)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .RESET_UOP  (RESET_UOP),
    .READ_FLAGS (READ_FLAGS),
    .ZERO_IN    (ZERO_IN),
    .COUT_IN    (COUT_IN),
    .RUN        (RUN),
    .HALT       (HALT),
    .STEP       (STEP),
    .UOP        (UOP),
    .ZERO_FLAG  (ZERO_FLAG),
    .COUT_FLAG  (COUT_FLAG),
    .BUSY       (BUSY),
    .HALTED     (HALTED),
    .FAULT      (FAULT),
    .INSTR_CNT  (INSTR_CNT)
  );

  always #5 CLK = ~CLK;

`ifdef UOP_SEQUENCER_INSTR_CNT_EN
  localparam int PRELOAD = 65534;
  localparam bit CNT_EN  = 1'b1;
`else
  localparam int PRELOAD = 0;
  localparam bit CNT_EN  = 1'b0;
`endif

  typedef struct {
    string      name;
    bit         rst, ru, rf, zi, ci, run, halt, step;
    logic [2:0] uop;
    bit         zf, cf, busy, halted, fault, inc;
  } vec_t;

  typedef struct {
    string       name;
    logic [2:0]  uop;
    logic        zf, cf, busy, halted, fault;
    logic [15:0] cnt;
  } exp_t;

  vec_t        tbl[$];
  exp_t        sb[$];
  logic [15:0] model_cnt = '0;
  int          n_checks  = 0;
  int          n_fail    = 0;

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", n, act, exp);
    end
  endtask

  function automatic void add(input string n,
      input bit rst, ru, rf, zi, ci, run, halt, step,
      input logic [2:0] uop, input bit zf, cf, busy, halted, fault, inc);
    vec_t v;
    v.name = n;  v.rst = rst; v.ru = ru; v.rf = rf; v.zi = zi; v.ci = ci;
    v.run = run; v.halt = halt; v.step = step;
    v.uop = uop; v.zf = zf; v.cf = cf; v.busy = busy; v.halted = halted;
    v.fault = fault; v.inc = inc;
    tbl.push_back(v);
  endfunction

  task automatic compare_out();
    exp_t e;
    if (sb.size() == 0) begin
      check("scoreboard underflow", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check({e.name, ".uop"},    32'(UOP),       32'(e.uop));
    check({e.name, ".zero"},   32'(ZERO_FLAG), 32'(e.zf));
    check({e.name, ".cout"},   32'(COUT_FLAG), 32'(e.cf));
    check({e.name, ".busy"},   32'(BUSY),      32'(e.busy));
    check({e.name, ".halted"}, 32'(HALTED),    32'(e.halted));
    check({e.name, ".fault"},  32'(FAULT),     32'(e.fault));
    check({e.name, ".cnt"},    32'(INSTR_CNT), 32'(e.cnt));
  endtask

  task automatic apply(input vec_t v);
    exp_t e;
    @(negedge CLK);
    RESET = v.rst; RESET_UOP = v.ru; READ_FLAGS = v.rf; ZERO_IN = v.zi; COUT_IN = v.ci;
    RUN = v.run; HALT = v.halt; STEP = v.step;
    if (v.rst)      model_cnt = '0;
    else if (v.inc) model_cnt = model_cnt + 16'd1;
    e.name = v.name; e.uop = v.uop; e.zf = v.zf; e.cf = v.cf; e.busy = v.busy;
    e.halted = v.halted; e.fault = v.fault;
    e.cnt = CNT_EN ? model_cnt : 16'd0;
    sb.push_back(e);
    @(posedge CLK);
    #1;
    compare_out();
  endtask

  initial begin
    vec_t w;
    RESET = 1'b1; RESET_UOP = 1'b0; READ_FLAGS = 1'b0; ZERO_IN = 1'b0; COUT_IN = 1'b0;
    RUN = 1'b0; HALT = 1'b0; STEP = 1'b0;

    //    name          rst ru rf zi ci rn ht st  uop zf cf by hd ft inc
    add("reset",         1, 0, 0, 0, 0, 0, 0, 0,  7, 0, 0, 0, 0, 0, 0);
    add("idle_to_run",   0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0);
    add("a_u1",          0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 1, 0, 0, 0);
    add("a_u2",          0, 0, 0, 0, 0, 0, 0, 0,  2, 0, 0, 1, 0, 0, 0);
    add("a_u3",          0, 0, 0, 0, 0, 0, 0, 0,  3, 0, 0, 1, 0, 0, 0);
    add("a_retire_u3",   0, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 1);
    add("b_u1",          0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 1, 0, 0, 0);
    add("b_halt_u1",     0, 0, 0, 0, 0, 0, 1, 0,  2, 0, 0, 1, 0, 0, 0);
    add("b_pend_u3",     0, 0, 0, 0, 0, 0, 0, 0,  3, 0, 0, 1, 0, 0, 0);
    add("b_pend_u4",     0, 0, 0, 0, 0, 0, 0, 0,  4, 0, 0, 1, 0, 0, 0);
    add("b_retire_halt", 0, 1, 0, 0, 0, 0, 0, 0,  7, 0, 0, 0, 1, 0, 1);
    add("c_hold",        0, 0, 0, 0, 0, 0, 0, 0,  7, 0, 0, 0, 1, 0, 0);
    add("c_step",        0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 1, 0, 0, 0);
    add("c_s1",          0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 1, 0, 0, 0);
    add("c_s2",          0, 0, 0, 0, 0, 0, 0, 0,  2, 0, 0, 1, 0, 0, 0);
    add("c_s3",          0, 0, 0, 0, 0, 0, 0, 0,  3, 0, 0, 1, 0, 0, 0);
    add("c_step_done",   0, 1, 0, 0, 0, 0, 0, 0,  7, 0, 0, 0, 1, 0, 1);
    add("c_run_halt",    0, 0, 0, 0, 0, 1, 1, 0,  7, 0, 0, 0, 1, 0, 0);
    add("c_run_over_st", 0, 0, 0, 0, 0, 1, 0, 1,  0, 0, 0, 1, 0, 0, 0);
    add("d_u1",          0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 1, 0, 0, 0);
    add("d_u2",          0, 0, 0, 0, 0, 0, 0, 0,  2, 0, 0, 1, 0, 0, 0);
    add("d_u3",          0, 0, 0, 0, 0, 0, 0, 0,  3, 0, 0, 1, 0, 0, 0);
    add("d_u4",          0, 0, 0, 0, 0, 0, 0, 0,  4, 0, 0, 1, 0, 0, 0);
    add("d_flags_u4",    0, 0, 1, 1, 0, 0, 0, 0,  5, 1, 0, 1, 0, 0, 0);
    add("d_flags_u5",    0, 0, 1, 0, 1, 0, 0, 0,  6, 0, 1, 1, 0, 0, 0);
    add("d_retire_hold", 0, 1, 0, 1, 0, 0, 0, 0,  0, 0, 1, 1, 0, 0, 1);
    add("e_halt_retire", 0, 1, 0, 0, 0, 0, 1, 0,  7, 0, 1, 0, 1, 0, 1);
    add("e_rf_in_halt",  0, 0, 1, 1, 0, 0, 0, 0,  7, 0, 1, 0, 1, 0, 0);
    add("e_run",         0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 1, 1, 0, 0, 0);
    add("e_step_ignore", 0, 0, 0, 0, 0, 0, 0, 1,  1, 0, 1, 1, 0, 0, 0);
    add("e_run_ignore",  0, 0, 0, 0, 0, 1, 0, 0,  2, 0, 1, 1, 0, 0, 0);
    add("f_rst_mid",     1, 1, 1, 1, 1, 0, 0, 0,  7, 0, 0, 0, 0, 0, 0);
    add("f_u0",          0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0);
    add("f_u1",          0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 1, 0, 0, 0);
    add("f_u2",          0, 0, 0, 0, 0, 0, 0, 0,  2, 0, 0, 1, 0, 0, 0);
    add("f_u3",          0, 0, 0, 0, 0, 0, 0, 0,  3, 0, 0, 1, 0, 0, 0);
    add("f_u4",          0, 0, 0, 0, 0, 0, 0, 0,  4, 0, 0, 1, 0, 0, 0);
    add("f_u5",          0, 0, 0, 0, 0, 0, 0, 0,  5, 0, 0, 1, 0, 0, 0);
    add("f_u6",          0, 0, 0, 0, 0, 0, 0, 0,  6, 0, 0, 1, 0, 0, 0);
    add("f_runaway",     0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 1, 0);
    add("f_sticky",      0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 1, 0, 1, 0);
    add("f_retire",      0, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 1, 1);
    add("f_rst_clear",   1, 0, 0, 0, 0, 0, 0, 0,  7, 0, 0, 0, 0, 0, 0);
    add("w_release",     0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // Drive the counter up to 0xFFFE with back-to-back single-micro-op instructions.
    @(negedge CLK);
    RESET_UOP = 1'b1;
    repeat (PRELOAD) @(posedge CLK);
    model_cnt = model_cnt + 16'(PRELOAD);

    w.name = "w_ffff"; w.rst = 0; w.ru = 1; w.rf = 0; w.zi = 0; w.ci = 0;
    w.run = 0; w.halt = 0; w.step = 0;
    w.uop = 3'd0; w.zf = 0; w.cf = 0; w.busy = 1; w.halted = 0; w.fault = 0; w.inc = 1;
    apply(w);
    if (CNT_EN) check("w_ffff.value", 32'(INSTR_CNT), 32'hFFFF);
    w.name = "w_0000";
    apply(w);
    check("w_0000.value", 32'(INSTR_CNT), 32'h0000);

    check("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
